// File: rtl/bist_march_ctrl_pkg.sv
// Shared definitions for the March C- BIST sequencer: states, element codes,
// op types, background values and the per-element op table.
package bist_march_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ELEM_M0 = 3'd0,
    ELEM_M1 = 3'd1,
    ELEM_M2 = 3'd2,
    ELEM_M3 = 3'd3,
    ELEM_M4 = 3'd4,
    ELEM_M5 = 3'd5
  } elem_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_type_e;

  localparam logic BG_ZERO = 1'b0;
  localparam logic BG_ONE  = 1'b1;

  // Two-op elements read first, then write the complement background.
  function automatic op_type_e op_kind(elem_e elem, logic op_idx);
    case (elem)
      ELEM_M0: return OP_WRITE;
      ELEM_M5: return OP_READ;
      default: return op_type_e'(op_idx);
    endcase
  endfunction

  function automatic logic op_bg(elem_e elem, logic op_idx);
    case (elem)
      ELEM_M1, ELEM_M3: return op_idx ? BG_ONE : BG_ZERO;
      ELEM_M2, ELEM_M4: return op_idx ? BG_ZERO : BG_ONE;
      default:          return BG_ZERO;
    endcase
  endfunction

  function automatic logic op_last(elem_e elem, logic op_idx);
    return (elem == ELEM_M0) || (elem == ELEM_M5) || op_idx;
  endfunction

  function automatic logic elem_is_down(elem_e elem);
    return (elem == ELEM_M3) || (elem == ELEM_M4);
  endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter with parallel load and a terminal-count flag
// that depends on the current counting direction.
module bist_addr_gen #(
  parameter int pADDR_WIDTH = 2
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   load_i,
  input  logic [pADDR_WIDTH-1:0] load_val_i,
  input  logic                   step_i,
  input  logic                   down_i,
  output logic [pADDR_WIDTH-1:0] addr_o,
  output logic                   tc_o
);

  logic [pADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      addr_q <= '0;
    end else if (load_i) begin
      addr_q <= load_val_i;
    end else if (step_i) begin
      addr_q <= down_i ? addr_q - 1'b1 : addr_q + 1'b1;
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = down_i ? (addr_q == '0) : (addr_q == {pADDR_WIDTH{1'b1}});

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- sequencer: one full pass per start, sticky fail, DRAIN to catch the
// last read result. Optional first-fail logging under `BIST_FAIL_LOG_EN.
module bist_march_ctrl
  import bist_march_ctrl_pkg::*;
#(
  parameter int pADDR_WIDTH = 2,
  parameter int pDATA_WIDTH = 2
) (
  input  logic                   bist_clk,
  input  logic                   bist_rst,
  input  logic                   bist_start,
  input  logic                   pass_or_fail,
  output logic                   bist_cs,
  output logic                   bist_we,
  output logic [pADDR_WIDTH-1:0] bist_addr,
  output logic [pDATA_WIDTH-1:0] bist_pat,
  output logic                   bist_busy,
  output logic                   bist_done,
`ifdef BIST_FAIL_LOG_EN
  output logic [pADDR_WIDTH-1:0] bist_fail_addr,
  output logic [2:0]             bist_fail_elem,
`endif
  output logic                   bist_fail
);

  state_e                 state_q;
  elem_e                  elem_q, elem_d;
  logic                   op_q, op_d;
  logic                   cs_q, we_q, busy_q, done_q, fail_q, rd_q;
  logic [pDATA_WIDTH-1:0] pat_q;

  logic                   ag_load, ag_step, ag_tc;
  logic [pADDR_WIDTH-1:0] ag_load_val, ag_addr;
  logic                   start_ok, in_run, run_end;

  assign start_ok = bist_start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_run   = (state_q == ST_RUN);
  assign run_end  = in_run && op_last(elem_q, op_q) && ag_tc && (elem_q == ELEM_M5);

  // Next op: finish the current address, then advance address, then element.
  always_comb begin
    elem_d      = elem_q;
    op_d        = op_q;
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_step     = 1'b0;
    if (start_ok) begin
      elem_d  = ELEM_M0;
      op_d    = 1'b0;
      ag_load = 1'b1;
    end else if (in_run) begin
      if (!op_last(elem_q, op_q)) begin
        op_d = 1'b1;
      end else begin
        op_d = 1'b0;
        if (!ag_tc) begin
          ag_step = 1'b1;
        end else if (elem_q == ELEM_M5) begin
          ag_load = 1'b1;
        end else begin
          elem_d      = elem_e'(elem_q + 3'd1);
          ag_load     = 1'b1;
          ag_load_val = elem_is_down(elem_d) ? {pADDR_WIDTH{1'b1}} : '0;
        end
      end
    end
  end

  bist_addr_gen #(.pADDR_WIDTH(pADDR_WIDTH)) u_addr_gen (
    .clk_i      (bist_clk),
    .srst_i     (bist_rst),
    .load_i     (ag_load),
    .load_val_i (ag_load_val),
    .step_i     (ag_step),
    .down_i     (elem_is_down(elem_q)),
    .addr_o     (ag_addr),
    .tc_o       (ag_tc)
  );

`ifdef BIST_FAIL_LOG_EN
  logic [pADDR_WIDTH-1:0] rd_addr_q, fail_addr_q;
  logic [2:0]             rd_elem_q, fail_elem_q;
`endif

  always_ff @(posedge bist_clk) begin
    if (bist_rst) begin
      state_q <= ST_IDLE;
      elem_q  <= ELEM_M0;
      op_q    <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      rd_q    <= 1'b0;
`ifdef BIST_FAIL_LOG_EN
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
`endif
    end else begin
      elem_q <= elem_d;
      op_q   <= op_d;
      rd_q   <= cs_q & ~we_q;
      if (rd_q && !pass_or_fail) fail_q <= 1'b1;
`ifdef BIST_FAIL_LOG_EN
      rd_addr_q <= ag_addr;
      rd_elem_q <= elem_q;
      if (rd_q && !pass_or_fail && !fail_q) begin
        fail_addr_q <= rd_addr_q;
        fail_elem_q <= rd_elem_q;
      end
`endif
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bist_start) begin
            state_q <= ST_RUN;
            cs_q    <= 1'b1;
            we_q    <= (op_kind(elem_d, op_d) == OP_WRITE);
            pat_q   <= {pDATA_WIDTH{op_bg(elem_d, op_d)}};
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
`ifdef BIST_FAIL_LOG_EN
            fail_addr_q <= '0;
            fail_elem_q <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (run_end) begin
            state_q <= ST_DRAIN;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            pat_q   <= '0;
          end else begin
            cs_q  <= 1'b1;
            we_q  <= (op_kind(elem_d, op_d) == OP_WRITE);
            pat_q <= {pDATA_WIDTH{op_bg(elem_d, op_d)}};
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bist_cs   = cs_q;
  assign bist_we   = we_q;
  assign bist_addr = ag_addr;
  assign bist_pat  = pat_q;
  assign bist_busy = busy_q;
  assign bist_done = done_q;
  assign bist_fail = fail_q;
`ifdef BIST_FAIL_LOG_EN
  assign bist_fail_addr = fail_addr_q;
  assign bist_fail_elem = fail_elem_q;
`endif

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Directed bench for bist_march_ctrl: N=4 instance with a small memory +
// comparator model, and an N=8 instance for the address-width case.
module tb_bist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start8 = 1'b0;
  logic       pof = 1'b1;
  logic       pof8 = 1'b1;

  logic       cs, we, busy, done, fail;
  logic [1:0] addr, pat;
  logic       cs8, we8, busy8, done8, fail8;
  logic [2:0] addr8;
  logic [1:0] pat8;
`ifdef BIST_FAIL_LOG_EN
  logic [1:0] fail_addr;
  logic [2:0] fail_elem;
  logic [2:0] fail_addr8;
  logic [2:0] fail_elem8;
`endif

  always #5 clk = ~clk;

  bist_march_ctrl #(.pADDR_WIDTH(2), .pDATA_WIDTH(2)) dut (
    .bist_clk(clk), .bist_rst(rst), .bist_start(start), .pass_or_fail(pof),
    .bist_cs(cs), .bist_we(we), .bist_addr(addr), .bist_pat(pat),
    .bist_busy(busy), .bist_done(done),
`ifdef BIST_FAIL_LOG_EN
    .bist_fail_addr(fail_addr), .bist_fail_elem(fail_elem),
`endif
    .bist_fail(fail)
  );

  bist_march_ctrl #(.pADDR_WIDTH(3), .pDATA_WIDTH(2)) dut8 (
    .bist_clk(clk), .bist_rst(rst), .bist_start(start8), .pass_or_fail(pof8),
    .bist_cs(cs8), .bist_we(we8), .bist_addr(addr8), .bist_pat(pat8),
    .bist_busy(busy8), .bist_done(done8),
`ifdef BIST_FAIL_LOG_EN
    .bist_fail_addr(fail_addr8), .bist_fail_elem(fail_elem8),
`endif
    .bist_fail(fail8)
  );

  // Memory + registered comparator for the N=4 instance.
  logic [1:0] mem [4];
  logic       stuck_en = 1'b0;
  logic       force_fail = 1'b0;

  always @(posedge clk) begin
    pof <= 1'b1;
    if (cs && !we)
      pof <= (((mem[addr] | ((stuck_en && addr == 2'd2) ? 2'b01 : 2'b00)) == pat) && !force_fail);
    if (cs && we) mem[addr] <= pat;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  // March C- table: 0=r0 1=r1 2=w0 3=w1
  int op_tab [6][2] = '{'{2, 0}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};
  int nops_tab [6] = '{1, 2, 2, 2, 2, 1};

  typedef struct {int we; int addr; int pat;} exp_op_t;
  exp_op_t exp_q[$];

  task automatic build_exp(input int n);
    exp_op_t e;
    exp_q.delete();
    for (int el = 0; el < 6; el++)
      for (int k = 0; k < n; k++)
        for (int o = 0; o < nops_tab[el]; o++) begin
          e.we   = (op_tab[el][o] >= 2) ? 1 : 0;
          e.addr = (el == 3 || el == 4) ? n - 1 - k : k;
          e.pat  = (op_tab[el][o] % 2 == 1) ? 3 : 0;
          exp_q.push_back(e);
        end
  endtask

  function automatic int pack_op(input logic c, input logic w, input int a, input int p);
    return (int'(c) << 12) | (int'(w) << 8) | (a << 4) | p;
  endfunction

  logic fail_hist [40];
  logic fail_drain;

  // Full N=4 run; ends in cycle E+42 (first DONE cycle).
  task automatic run_main(input bit hold_start, input bit force_last);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); if (!hold_start) start = 1'b0;
    check("start_clr busy/done/fail", {busy, done, fail}, 3'b100);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("op%0d", i), pack_op(cs, we, int'(addr), int'(pat)),
            pack_op(1'b1, exp_q[i].we[0], exp_q[i].addr, exp_q[i].pat));
      fail_hist[i] = fail;
      force_fail = force_last && (i == 39);
      if (i == 39) start = 1'b0;
      @(negedge clk);
    end
    force_fail = 1'b0;
    check("drain cs/we/pat/busy/done", {cs, we, pat, busy, done}, 6'b000010);
    fail_drain = fail;
    @(negedge clk);
    check("done busy/done/cs", {busy, done, cs}, 3'b010);
    $display("run done: done=%0b fail=%0b", done, fail);
  endtask

  initial begin
    build_exp(4);
    repeat (3) @(negedge clk);
    check("reset dut4", {cs, we, busy, done, fail, addr, pat}, 0);
    check("reset dut8", {cs8, we8, busy8, done8, fail8, addr8, pat8}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: fault-free pass
    run_main(1'b0, 1'b0);
    check("t1 fail", fail, 0);

    // 2: stuck-at-1 on bit0 of addr 2
    stuck_en = 1'b1;
    run_main(1'b0, 1'b0);
    stuck_en = 1'b0;
    check("t2 fail before M1 r0 result", fail_hist[9], 0);
    check("t2 fail after M1 r0 addr2", fail_hist[10], 1);
    check("t2 fail at done", fail, 1);
`ifdef BIST_FAIL_LOG_EN
    check("t2 fail_addr", fail_addr, 2);
    check("t2 fail_elem", fail_elem, 1);
`endif

    // 3: miscompare only on final M5 read; also restart from DONE with fail set
    run_main(1'b0, 1'b1);
    check("t3 fail at op39", fail_hist[39], 0);
    check("t3 fail in drain", fail_drain, 0);
    check("t3 fail at done", fail, 1);
`ifdef BIST_FAIL_LOG_EN
    check("t3 fail_addr", fail_addr, 3);
    check("t3 fail_elem", fail_elem, 5);
`endif

    // 4: reset during op cycle 17
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (17) @(negedge clk);
    check("t4 op17 busy", {cs, busy}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4 reset outputs", {cs, we, busy, done, fail, addr, pat}, 0);
`ifdef BIST_FAIL_LOG_EN
    check("t4 reset log", {fail_addr, fail_elem}, 0);
`endif
    repeat (2) @(negedge clk);
    check("t4 idle after reset", {cs, busy}, 0);
    run_main(1'b0, 1'b0);
    check("t4 clean rerun fail", fail, 0);

    // 5: start held high through the run
    run_main(1'b1, 1'b0);
    check("t5 fail", fail, 0);
    repeat (2) @(negedge clk);
    check("t5 stays done", {done, cs}, 2'b10);

    // 6: pADDR_WIDTH=3
    build_exp(8);
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      check($sformatf("n8 op%0d", i), pack_op(cs8, we8, int'(addr8), int'(pat8)),
            pack_op(1'b1, exp_q[i].we[0], exp_q[i].addr, exp_q[i].pat));
      if (i == 40) check("n8 M3 first addr", addr8, 7);
      if (i == 55) check("n8 M3 last addr", addr8, 0);
      if (i == 56) check("n8 M4 first addr", addr8, 7);
      if (i == 71) check("n8 M4 last addr", addr8, 0);
      @(negedge clk);
    end
    check("n8 drain", {cs8, busy8, done8}, 3'b010);
    @(negedge clk);
    check("n8 done", {cs8, busy8, done8, fail8}, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
